qspi_read_seq: RTL and testbench

// Sequences a quad-I/O flash read (cmd, addr, mode, dummy, data) on the QSPI

---
 rtl/qspi_read_seq_if.sv | 36 +++
 rtl/qspi_read_seq.sv | 214 +++++++++++++++++++++
 tb/tb_qspi_read_seq.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_read_seq_if.sv
// Bus bundle between the QSPI read sequencer, the fetch logic, the pad ring
// and the push side of the QSPI FIFO.
//   fetch side : start, addr, nbytes, stop -> ; <- busy, done
//   pad side   : <- sck, cs_n, io_out, io_oe ; io_in ->
//   fifo side  : <- fifo_clear, fifo_push, fifo_push_data ; fifo_count ->
// The sequencer connects through the slave modport; whoever drives it
// (fetch logic, pads, FIFO model) uses the master modport.
interface qspi_read_seq_if;
   logic        start;
   logic [23:0] addr;
   logic [7:0]  nbytes;
   logic        stop;
   logic        busy;
   logic        done;
   logic        sck;
   logic        cs_n;
   logic [3:0]  io_out;
   logic [3:0]  io_oe;
   logic [3:0]  io_in;
   logic        fifo_clear;
   logic        fifo_push;
   logic [3:0]  fifo_push_data;
   logic [4:0]  fifo_count;

   modport slave (
      input  start, addr, nbytes, stop, io_in, fifo_count,
      output busy, done, sck, cs_n, io_out, io_oe,
             fifo_clear, fifo_push, fifo_push_data
   );

   modport master (
      output start, addr, nbytes, stop, io_in, fifo_count,
      input  busy, done, sck, cs_n, io_out, io_oe,
             fifo_clear, fifo_push, fifo_push_data
   );
endinterface

// File: rtl/qspi_read_seq.sv
// Quad-I/O flash read sequencer. Drives opcode, address, mode and dummy
// phases on the QSPI pins, then streams received nibbles into the push side
// of the QSPI FIFO. SCK runs at clk/2 and is held low in DATA whenever the
// FIFO (counting a push in flight) is above STALL_LVL.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : qspi_read_seq_if.slave (fetch handshake, pads, FIFO push side)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | cs_n high, waiting for start
// ST_CMD    | 8 periods, opcode serial on IO0, MSB first
// ST_ADDR   | 6 periods, address nibbles [23:20] first, quad out
// ST_MODE   | 2 periods, mode byte high nibble then low nibble
// ST_DUMMY  | DUMMY periods, pads tri-stated
// ST_DATA   | pads tri-stated, sample io_in each period, push to FIFO
// ST_END    | cs_n high for CS_HIGH cycles, then IDLE with done pulse
//
// Every SCK period is a LOW cycle (hi_q=0, pins updated) then a HIGH cycle
// (hi_q=1). Stop and stall are only evaluated at the end of a LOW cycle.
module qspi_read_seq #(
   parameter logic [7:0]  CMD       = 8'hEB,
   parameter logic [7:0]  MODE      = 8'h00,
   parameter int unsigned DUMMY     = 4,
   parameter int unsigned STALL_LVL = 20,
   parameter int unsigned CS_HIGH   = 2
) (
   input logic            clk,
   input logic            rst,
   qspi_read_seq_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_MODE,
      ST_DUMMY,
      ST_DATA,
      ST_END
   } state_t;

   state_t      state_q;
   logic        hi_q;
   logic [7:0]  cnt_q;
   logic [6:0]  cmd_sh_q;
   logic [23:0] addr_sh_q;
   logic [8:0]  nib_left_q;
   logic        stream_q;

   logic        sck_q;
   logic        cs_n_q;
   logic [3:0]  io_out_q;
   logic [3:0]  io_oe_q;
   logic        busy_q;
   logic        done_q;
   logic        clear_q;
   logic        push_q;
   logic [3:0]  push_data_q;

   // The FIFO only sees our push at the next edge, so count it here too.
   logic [5:0]  occ_d;
   logic        stall_d;

   assign occ_d   = {1'b0, bus.fifo_count} + (push_q ? 6'd2 : 6'd0);
   assign stall_d = (occ_d > 6'(STALL_LVL));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hi_q        <= 1'b0;
         cnt_q       <= '0;
         cmd_sh_q    <= '0;
         addr_sh_q   <= '0;
         nib_left_q  <= '0;
         stream_q    <= 1'b0;
         sck_q       <= 1'b0;
         cs_n_q      <= 1'b1;
         io_out_q    <= '0;
         io_oe_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         clear_q     <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
      end else begin
         done_q  <= 1'b0;
         clear_q <= 1'b0;
         push_q  <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q    <= ST_CMD;
                  hi_q       <= 1'b0;
                  cnt_q      <= 8'd7;
                  cmd_sh_q   <= CMD[6:0];
                  addr_sh_q  <= bus.addr;
                  nib_left_q <= {bus.nbytes, 1'b0};
                  stream_q   <= (bus.nbytes == 8'd0);
                  cs_n_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  clear_q    <= 1'b1;
                  sck_q      <= 1'b0;
                  io_oe_q    <= 4'b0001;
                  io_out_q   <= {3'b000, CMD[7]};
               end
            end

            ST_END: begin
               if (cnt_q == 8'd0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end

            default: begin
               if (!hi_q) begin
                  if (bus.stop) begin
                     state_q  <= ST_END;
                     cnt_q    <= 8'(CS_HIGH - 1);
                     cs_n_q   <= 1'b1;
                     sck_q    <= 1'b0;
                     io_oe_q  <= '0;
                     io_out_q <= '0;
                  end else if (!(state_q == ST_DATA && stall_d)) begin
                     hi_q  <= 1'b1;
                     sck_q <= 1'b1;
                  end
               end else begin
                  hi_q  <= 1'b0;
                  sck_q <= 1'b0;
                  case (state_q)
                     ST_CMD: begin
                        if (cnt_q == 8'd0) begin
                           state_q  <= ST_ADDR;
                           cnt_q    <= 8'd5;
                           io_oe_q  <= 4'hF;
                           io_out_q <= addr_sh_q[23:20];
                        end else begin
                           cnt_q    <= cnt_q - 8'd1;
                           cmd_sh_q <= {cmd_sh_q[5:0], 1'b0};
                           io_out_q <= {3'b000, cmd_sh_q[6]};
                        end
                     end
                     ST_ADDR: begin
                        if (cnt_q == 8'd0) begin
                           state_q  <= ST_MODE;
                           cnt_q    <= 8'd1;
                           io_out_q <= MODE[7:4];
                        end else begin
                           cnt_q     <= cnt_q - 8'd1;
                           addr_sh_q <= {addr_sh_q[19:0], 4'h0};
                           io_out_q  <= addr_sh_q[19:16];
                        end
                     end
                     ST_MODE: begin
                        if (cnt_q == 8'd0) begin
                           io_oe_q  <= '0;
                           io_out_q <= '0;
                           if (DUMMY == 0) begin
                              state_q <= ST_DATA;
                           end else begin
                              state_q <= ST_DUMMY;
                              cnt_q   <= 8'(DUMMY - 1);
                           end
                        end else begin
                           cnt_q    <= cnt_q - 8'd1;
                           io_out_q <= MODE[3:0];
                        end
                     end
                     ST_DUMMY: begin
                        if (cnt_q == 8'd0) begin
                           state_q <= ST_DATA;
                        end else begin
                           cnt_q <= cnt_q - 8'd1;
                        end
                     end
                     ST_DATA: begin
                        push_q      <= 1'b1;
                        push_data_q <= bus.io_in;
                        nib_left_q  <= nib_left_q - 9'd1;
                        // Last nibble: its push still issues during END.
                        if (!stream_q && nib_left_q == 9'd1) begin
                           state_q  <= ST_END;
                           cnt_q    <= 8'(CS_HIGH - 1);
                           cs_n_q   <= 1'b1;
                           io_oe_q  <= '0;
                           io_out_q <= '0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.sck            = sck_q;
   assign bus.cs_n           = cs_n_q;
   assign bus.io_out         = io_out_q;
   assign bus.io_oe          = io_oe_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.fifo_clear     = clear_q;
   assign bus.fifo_push      = push_q;
   assign bus.fifo_push_data = push_data_q;

endmodule

// File: tb/tb_qspi_read_seq.sv
module tb_qspi_read_seq;
   localparam logic [7:0] CMD_EXP   = 8'hEB;
   localparam logic [7:0] MODE_EXP  = 8'h00;
   localparam int         DUMMY_EXP = 4;
   localparam int         HDR       = 8 + 6 + 2 + DUMMY_EXP;
   localparam int         STALL_EXP = 20;
   localparam int         CSH_EXP   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   qspi_read_seq_if bus ();

   qspi_read_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Flash/FIFO model state, updated once per falling edge.
   logic [3:0] per_out[$];
   logic [3:0] per_oe[$];
   logic [3:0] exp_nib[$];
   logic [3:0] got_nib[$];
   int occ        = 0;
   int pend       = 0;
   int max_occ    = 0;
   int pop_target = -1;
   int n_done     = 0;
   int n_clear    = 0;
   int n_end      = 0;
   int period     = 0;
   bit drain      = 1'b1;

   always @(negedge clk) begin
      logic [3:0] nib;
      occ  = occ + pend;
      pend = (bus.fifo_push === 1'b1) ? 2 : 0;
      if (occ > max_occ) max_occ = occ;
      if (drain) occ = 0;
      if (pop_target >= 0 && occ > pop_target) occ = pop_target;
      if (bus.fifo_clear === 1'b1) begin
         occ    = 0;
         period = 0;
         n_clear++;
      end
      bus.fifo_count = 5'(occ);
      nib = 4'($urandom);
      bus.io_in = nib;
      if (bus.sck === 1'b1) begin
         per_out.push_back(bus.io_out);
         per_oe.push_back(bus.io_oe);
         if (period >= HDR) exp_nib.push_back(nib);
         period++;
      end
      if (bus.fifo_push === 1'b1) got_nib.push_back(bus.fifo_push_data);
      if (bus.done === 1'b1) n_done++;
      if (bus.busy === 1'b1 && bus.cs_n === 1'b1) n_end++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      per_out.delete();
      per_oe.delete();
      exp_nib.delete();
      got_nib.delete();
      n_done     = 0;
      n_clear    = 0;
      n_end      = 0;
      max_occ    = 0;
      pop_target = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      total++; if (bus.cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b exp=1", bus.cs_n); end
      total++; if (bus.sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", bus.sck); end
      total++; if (bus.io_out !== 4'h0 || bus.io_oe !== 4'h0) begin bad++; $display("FAIL reset_io got out=%h oe=%h exp 0 0", bus.io_out, bus.io_oe); end
      total++; if ({bus.busy, bus.done, bus.fifo_push, bus.fifo_clear} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.done, bus.fifo_push, bus.fifo_clear}); end
      rst = 1'b0;
      step(2);
      total++; if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin bad++; $display("FAIL idle_after_reset busy=%b cs_n=%b exp 0 1", bus.busy, bus.cs_n); end
   endtask

   task automatic test_basic(input logic [23:0] a, input logic [7:0] nb);
      int k, n_per, cmd_e, addr_e, mode_e, tri_e, dat_e;
      logic [7:0] cmdv, modev;
      logic [3:0] e;
      cmdv  = CMD_EXP;
      modev = MODE_EXP;
      n_per = HDR + 2 * int'(nb);
      clear_mon();
      drain = 1'b1;
      bus.addr = a;
      bus.nbytes = nb;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      total++; if ({bus.cs_n, bus.busy, bus.fifo_clear, bus.sck} !== 4'b0110) begin bad++; $display("FAIL start_latency got cs_n/busy/clear/sck=%b exp=0110", {bus.cs_n, bus.busy, bus.fifo_clear, bus.sck}); end
      total++; if (bus.io_oe !== 4'b0001 || bus.io_out[0] !== cmdv[7]) begin bad++; $display("FAIL first_cmd_bit got oe=%h io0=%b exp oe=1 io0=%b", bus.io_oe, bus.io_out[0], cmdv[7]); end
      k = 0;
      while (n_done == 0 && k < 2000) begin step(1); k++; end
      total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done got=%0d exp=1", n_done); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", bus.busy); end
      total++; if (per_out.size() !== n_per) begin bad++; $display("FAIL basic_periods got=%0d exp=%0d", per_out.size(), n_per); end
      cmd_e = 0; addr_e = 0; mode_e = 0; tri_e = 0;
      for (int i = 0; i < per_out.size() && i < n_per; i++) begin
         if (i < 8) begin
            if (per_oe[i] !== 4'b0001 || per_out[i][0] !== cmdv[7-i]) cmd_e++;
         end else if (i < 14) begin
            e = 4'(a >> (4 * (13 - i)));
            if (per_oe[i] !== 4'hF || per_out[i] !== e) addr_e++;
         end else if (i < 16) begin
            e = (i == 14) ? modev[7:4] : modev[3:0];
            if (per_oe[i] !== 4'hF || per_out[i] !== e) mode_e++;
         end else begin
            if (per_oe[i] !== 4'h0) tri_e++;
         end
      end
      total++; if (cmd_e !== 0) begin bad++; $display("FAIL cmd_pins got %0d bad periods exp 0", cmd_e); end
      total++; if (addr_e !== 0) begin bad++; $display("FAIL addr_pins got %0d bad periods exp 0 (addr=%h)", addr_e, a); end
      total++; if (mode_e !== 0) begin bad++; $display("FAIL mode_pins got %0d bad periods exp 0", mode_e); end
      total++; if (tri_e !== 0) begin bad++; $display("FAIL dummy_data_oe got %0d driven periods exp 0", tri_e); end
      total++; if (got_nib.size() !== 2 * int'(nb)) begin bad++; $display("FAIL basic_push_count got=%0d exp=%0d", got_nib.size(), 2 * int'(nb)); end
      dat_e = 0;
      for (int i = 0; i < got_nib.size() && i < exp_nib.size(); i++)
         if (got_nib[i] !== exp_nib[i]) dat_e++;
      total++; if (dat_e !== 0 || exp_nib.size() !== got_nib.size()) begin bad++; $display("FAIL basic_push_data got %0d wrong of %0d, sampled=%0d", dat_e, got_nib.size(), exp_nib.size()); end
      total++; if (n_clear !== 1) begin bad++; $display("FAIL basic_clear got=%0d exp=1", n_clear); end
      total++; if (n_end !== CSH_EXP) begin bad++; $display("FAIL basic_cs_high got=%0d exp=%0d", n_end, CSH_EXP); end
      step(2);
   endtask

   task automatic test_stall();
      int k, np, dat_e;
      clear_mon();
      drain = 1'b0;
      bus.addr = 24'($urandom);
      bus.nbytes = 8'd16;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      k = 0;
      while (got_nib.size() < 11 && k < 1000) begin step(1); k++; end
      step(10);
      np = period;
      step(20);
      total++; if (got_nib.size() !== 11) begin bad++; $display("FAIL stall_push_count got=%0d exp=11", got_nib.size()); end
      total++; if (period !== np || bus.sck !== 1'b0) begin bad++; $display("FAIL stall_sck_held got periods %0d->%0d sck=%b exp no change sck=0", np, period, bus.sck); end
      total++; if (bus.cs_n !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL stall_still_active cs_n=%b busy=%b exp 0 1", bus.cs_n, bus.busy); end
      pop_target = 18;
      step(1);
      pop_target = -1;
      k = 0;
      while (got_nib.size() <= 11 && k < 20) begin step(1); k++; end
      total++; if (got_nib.size() <= 11) begin bad++; $display("FAIL stall_resume got pushes=%0d exp >11", got_nib.size()); end
      k = 0;
      while (n_done == 0 && k < 5000) begin
         if (occ >= STALL_EXP && $urandom_range(0, 3) == 0) begin
            pop_target = 2 * int'($urandom_range(0, 9));
            step(1);
            pop_target = -1;
         end else begin
            step(1);
         end
         k++;
      end
      total++; if (n_done !== 1) begin bad++; $display("FAIL stall_done got=%0d exp=1", n_done); end
      total++; if (got_nib.size() !== 32) begin bad++; $display("FAIL stall_total_pushes got=%0d exp=32", got_nib.size()); end
      dat_e = 0;
      for (int i = 0; i < got_nib.size() && i < exp_nib.size(); i++)
         if (got_nib[i] !== exp_nib[i]) dat_e++;
      total++; if (dat_e !== 0 || exp_nib.size() !== got_nib.size()) begin bad++; $display("FAIL stall_push_data got %0d wrong, sampled=%0d pushed=%0d", dat_e, exp_nib.size(), got_nib.size()); end
      total++; if (max_occ > STALL_EXP + 2) begin bad++; $display("FAIL stall_overrun got max=%0d exp <=%0d", max_occ, STALL_EXP + 2); end
      drain = 1'b1;
      step(2);
   endtask

   task automatic test_stop_data();
      int k, dat_e;
      clear_mon();
      drain = 1'b1;
      bus.addr = 24'($urandom);
      bus.nbytes = 8'd0;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      k = 0;
      while (got_nib.size() < 5 && k < 1000) begin step(1); k++; end
      bus.stop = 1'b1;
      k = 0;
      while (n_done == 0 && k < 200) begin step(1); k++; end
      bus.stop = 1'b0;
      total++; if (got_nib.size() != 5 && got_nib.size() != 6) begin bad++; $display("FAIL stop_push_count got=%0d exp 5 or 6", got_nib.size()); end
      dat_e = 0;
      for (int i = 0; i < got_nib.size() && i < exp_nib.size(); i++)
         if (got_nib[i] !== exp_nib[i]) dat_e++;
      total++; if (dat_e !== 0 || exp_nib.size() !== got_nib.size()) begin bad++; $display("FAIL stop_push_data got %0d wrong, sampled=%0d pushed=%0d", dat_e, exp_nib.size(), got_nib.size()); end
      total++; if (n_end !== CSH_EXP) begin bad++; $display("FAIL stop_cs_high got=%0d exp=%0d", n_end, CSH_EXP); end
      step(5);
      total++; if (n_done !== 1) begin bad++; $display("FAIL stop_done_once got=%0d exp=1", n_done); end
   endtask

   task automatic test_stop_addr();
      int k;
      clear_mon();
      drain = 1'b1;
      bus.addr = 24'($urandom);
      bus.nbytes = 8'd3;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      k = 0;
      while (period < 10 && k < 100) begin step(1); k++; end
      bus.stop = 1'b1;
      k = 0;
      while (n_done == 0 && k < 100) begin step(1); k++; end
      bus.stop = 1'b0;
      total++; if (period !== 10) begin bad++; $display("FAIL addr_abort_periods got=%0d exp=10", period); end
      total++; if (got_nib.size() !== 0) begin bad++; $display("FAIL addr_abort_pushes got=%0d exp=0", got_nib.size()); end
      total++; if (n_done !== 1 || n_end !== CSH_EXP) begin bad++; $display("FAIL addr_abort_end got done=%0d cs_high=%0d exp 1 %0d", n_done, n_end, CSH_EXP); end
      step(2);
   endtask

   task automatic test_start_busy();
      int k, addr_e;
      logic [23:0] a1;
      logic [3:0] e;
      a1 = 24'($urandom);
      clear_mon();
      drain = 1'b1;
      bus.addr = a1;
      bus.nbytes = 8'd2;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(3);
      bus.addr = ~a1;
      bus.start = 1'b1;
      step(2);
      bus.start = 1'b0;
      k = 0;
      while (n_done == 0 && k < 500) begin step(1); k++; end
      total++; if (n_clear !== 1) begin bad++; $display("FAIL busy_start_clear got=%0d exp=1", n_clear); end
      addr_e = 0;
      for (int i = 8; i < 14 && i < per_out.size(); i++) begin
         e = 4'(a1 >> (4 * (13 - i)));
         if (per_out[i] !== e) addr_e++;
      end
      total++; if (addr_e !== 0 || per_out.size() < 14) begin bad++; $display("FAIL busy_start_addr got %0d wrong nibbles, periods=%0d exp 0", addr_e, per_out.size()); end
      total++; if (got_nib.size() !== 4) begin bad++; $display("FAIL busy_start_pushes got=%0d exp=4", got_nib.size()); end
      step(2);
      clear_mon();
      bus.stop = 1'b1;
      step(4);
      total++; if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1 || n_clear !== 0) begin bad++; $display("FAIL stop_idle_ignored busy=%b cs_n=%b clears=%0d exp 0 1 0", bus.busy, bus.cs_n, n_clear); end
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      bus.stop = 1'b0;
      total++; if (bus.busy !== 1'b1 || bus.cs_n !== 1'b0) begin bad++; $display("FAIL start_wins busy=%b cs_n=%b exp 1 0", bus.busy, bus.cs_n); end
      k = 0;
      while (n_done == 0 && k < 500) begin step(1); k++; end
      total++; if (n_clear !== 1 || n_done !== 1) begin bad++; $display("FAIL start_stop_pulses got clears=%0d dones=%0d exp 1 1", n_clear, n_done); end
      total++; if (got_nib.size() !== 4) begin bad++; $display("FAIL start_stop_pushes got=%0d exp=4", got_nib.size()); end
      step(2);
   endtask

   task automatic test_reset_mid();
      int k, g;
      clear_mon();
      drain = 1'b1;
      bus.addr = 24'($urandom);
      bus.nbytes = 8'd0;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      k = 0;
      while (got_nib.size() < 3 && k < 1000) begin step(1); k++; end
      rst = 1'b1;
      step(1);
      g = got_nib.size();
      for (int c = 0; c < 3; c++) begin
         total++;
         if ({bus.cs_n, bus.sck, bus.io_oe, bus.fifo_push, bus.done} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_mid_pins cycle %0d got cs_n/sck/oe/push/done=%b exp=10000000", c, {bus.cs_n, bus.sck, bus.io_oe, bus.fifo_push, bus.done});
         end
         if (c < 2) step(1);
      end
      rst = 1'b0;
      step(6);
      total++; if (n_done !== 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d exp=0", n_done); end
      total++; if (got_nib.size() !== g) begin bad++; $display("FAIL reset_mid_no_push got=%0d exp=%0d", got_nib.size(), g); end
      total++; if (bus.busy !== 1'b0 || bus.cs_n !== 1'b1) begin bad++; $display("FAIL reset_mid_idle busy=%b cs_n=%b exp 0 1", bus.busy, bus.cs_n); end
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.addr   = '0;
      bus.nbytes = '0;
      test_reset();
      test_basic(24'h123456, 8'd1);
      repeat (3) test_basic(24'($urandom), 8'($urandom_range(1, 3)));
      test_stall();
      test_stop_data();
      test_stop_addr();
      test_start_busy();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
